// File: rtl/serdes_rx_deframer_if.sv
// rtl/serdes_rx_deframer_if.sv - Valid/ready word port between the deframer and its parallel consumer.
interface serdes_rx_deframer_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/serdes_rx_deframer.sv
// rtl/serdes_rx_deframer.sv - Serial start/data/stop frame receiver presenting words on a valid/ready port.
// Optional even-parity bit between data and stop is enabled by SERDES_RX_PARITY_EN.
module serdes_rx_deframer #(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial_in,
    serdes_rx_deframer_if.master rx_if,
    output logic                 rx_busy,
    output logic                 frame_err,
`ifdef SERDES_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SERDES_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP, S_WAIT_IDLE} state_t;
`endif

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_frame_err;
    logic              r_overrun;
    logic              w_stop_edge;
    logic              w_good_stop;
    logic              w_accept;
    logic              w_par_bad;
`ifdef SERDES_RX_PARITY_EN
    logic              r_par_bit;
    logic              r_parity_err;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (!serial_in) w_next = S_DATA;
`ifdef SERDES_RX_PARITY_EN
            S_DATA:      if (r_cnt == LAST_BIT) w_next = S_PARITY;
            S_PARITY:    w_next = S_STOP;
`else
            S_DATA:      if (r_cnt == LAST_BIT) w_next = S_STOP;
`endif
            S_STOP:      w_next = serial_in ? S_IDLE : S_WAIT_IDLE;
            // A held-low break line parks here instead of looking like a new start bit.
            S_WAIT_IDLE: if (serial_in) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_stop_edge = (r_state == S_STOP);
        w_accept    = r_valid && rx_if.rx_ready;
`ifdef SERDES_RX_PARITY_EN
        w_par_bad   = (^r_shift) ^ r_par_bit;
`else
        w_par_bad   = 1'b0;
`endif
        w_good_stop = w_stop_edge && serial_in && !w_par_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SERDES_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= w_stop_edge && !serial_in;
`ifdef SERDES_RX_PARITY_EN
            r_parity_err <= w_stop_edge && serial_in && w_par_bad;
            if (r_state == S_PARITY) r_par_bit <= serial_in;
`endif
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (r_state == S_DATA) begin
                r_shift[r_cnt] <= serial_in;
                if (r_cnt != LAST_BIT) r_cnt <= r_cnt + 1'b1;
            end
            // A same-edge accept frees the slot, so the new word replaces the old one without overrun.
            if (w_good_stop && (!r_valid || rx_if.rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else begin
                if (w_accept) r_valid <= 1'b0;
                if (w_good_stop) r_overrun <= 1'b1;
            end
        end
    end

    assign rx_if.rx_data  = r_data;
    assign rx_if.rx_valid = r_valid;
    assign rx_busy        = (r_state != S_IDLE);
    assign frame_err      = r_frame_err;
    assign overrun        = r_overrun;
`ifdef SERDES_RX_PARITY_EN
    assign parity_err     = r_parity_err;
`endif
endmodule

// File: tb/tb_serdes_rx_deframer.sv
// tb/tb_serdes_rx_deframer.sv - Randomized frame stream against a frame-level reference model.
module tb_serdes_rx_deframer;
    localparam int DW = 8;
`ifdef SERDES_RX_PARITY_EN
    localparam int FL = DW + 3;
`else
    localparam int FL = DW + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic serial_in = 1'b1;
    logic rx_busy;
    logic frame_err;
    logic overrun;
    logic parity_err;

    serdes_rx_deframer_if #(.DATA_W(DW)) rx_if ();

    serdes_rx_deframer #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .serial_in (serial_in),
        .rx_if     (rx_if),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
`ifdef SERDES_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

`ifndef SERDES_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Per-cycle plan: line bit, ready, expected busy, event at this edge (1 good word, 2 framing, 3 parity).
    bit              q_line[$];
    bit              q_rdy[$];
    bit              q_busy[$];
    int              q_kind[$];
    logic [DW-1:0]   q_word[$];

    logic            m_valid = 1'b0;
    logic            m_ovr   = 1'b0;
    logic [DW-1:0]   m_data  = '0;

    task automatic push(input bit l, input bit r, input bit b, input int k, input logic [DW-1:0] w);
        q_line.push_back(l);
        q_rdy.push_back(r);
        q_busy.push_back(b);
        q_kind.push_back(k);
        q_word.push_back(w);
    endtask

    task automatic add_idle(input int n, input bit r);
        for (int i = 0; i < n; i++) push(1'b1, r, 1'b0, 0, '0);
    endtask

    function automatic bit pick_rdy(input int rmode, input bit at_stop);
        case (rmode)
            0:       return 1'b0;
            1:       return 1'b1;
            3:       return at_stop;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic add_frame(input logic [DW-1:0] w, input bit stop_ok, input bit par_ok,
                             input int low_len, input int gap, input int rmode);
        bit l;
        int k;
        for (int i = 0; i < FL; i++) begin
            if (i == 0) l = 1'b0;
            else if (i <= DW) l = w[i-1];
            else if (i == FL - 1) l = stop_ok;
            else l = par_ok ? (^w) : ~(^w);
            k = 0;
            if (i == FL - 1) k = !stop_ok ? 2 : (!par_ok ? 3 : 1);
            push(l, pick_rdy(rmode, i == FL - 1), (i < FL - 1) || !stop_ok, k, w);
        end
        if (!stop_ok) begin
            for (int i = 0; i < low_len; i++) push(1'b0, pick_rdy(rmode, 1'b0), 1'b1, 0, '0);
            push(1'b1, pick_rdy(rmode, 1'b0), 1'b0, 0, '0);
        end
        for (int i = 0; i < gap; i++) push(1'b1, pick_rdy(rmode, 1'b0), 1'b0, 0, '0);
    endtask

    task automatic run_stream();
        bit l, r, b;
        int k;
        logic [DW-1:0] w;
        while (q_line.size() > 0) begin
            l = q_line.pop_front();
            r = q_rdy.pop_front();
            b = q_busy.pop_front();
            k = q_kind.pop_front();
            w = q_word.pop_front();
            serial_in      = l;
            rx_if.rx_ready = r;
            @(posedge clk);
            #1;
            cyc++;
            if (m_valid && r) m_valid = 1'b0;
            if (k == 1) begin
                if (m_valid) m_ovr = 1'b1;
                else begin
                    m_valid = 1'b1;
                    m_data  = w;
                end
            end
            check("rx_valid", rx_if.rx_valid, m_valid);
            check("rx_data", rx_if.rx_data, m_data);
            check("overrun", overrun, m_ovr);
            check("frame_err", frame_err, k == 2);
            check("rx_busy", rx_busy, b);
            check("parity_err", parity_err, k == 3);
        end
    endtask

    task automatic add_random(input int n);
        logic [DW-1:0] w;
        bit so, po;
        for (int i = 0; i < n; i++) begin
            w  = DW'($urandom);
            so = ($urandom_range(0, 6) != 0);
`ifdef SERDES_RX_PARITY_EN
            po = ($urandom_range(0, 4) != 0);
`else
            po = 1'b1;
`endif
            add_frame(w, so, po, $urandom_range(0, 5),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : 2);
        end
        add_idle(3, 1'b1);
    endtask

    initial begin
        rx_if.rx_ready = 1'b0;
        #12;
        check("rst_valid", rx_if.rx_valid, 1'b0);
        check("rst_data", rx_if.rx_data, '0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        add_idle(1, 1'b0);
        add_frame(8'hA5, 1'b1, 1'b1, 0, 2, 1);
        add_frame(8'h3C, 1'b1, 1'b1, 0, 0, 0);
        add_frame(8'hC3, 1'b1, 1'b1, 0, 2, 0);
        add_idle(1, 1'b1);
        add_idle(2, 1'b0);
        add_frame(8'h55, 1'b0, 1'b1, 5, 0, 0);
        add_frame(8'h81, 1'b1, 1'b1, 0, 2, 1);
`ifdef SERDES_RX_PARITY_EN
        add_frame(8'h07, 1'b1, 1'b1, 0, 1, 1);
        add_frame(8'h07, 1'b1, 1'b0, 0, 1, 1);
`endif
        run_stream();

        // Break into data bit 4 of an 0xFF frame with an asynchronous reset.
        for (int i = 0; i < 5; i++) begin
            serial_in = (i == 0) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        #1;
        check("pre_rst_busy", rx_busy, 1'b1);
        check("pre_rst_overrun", overrun, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_valid", rx_if.rx_valid, 1'b0);
        check("async_data", rx_if.rx_data, '0);
        check("async_overrun", overrun, 1'b0);
        check("async_busy", rx_busy, 1'b0);
        check("async_frame_err", frame_err, 1'b0);
        serial_in = 1'b1;
        #1;
        rst_n   = 1'b1;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_data  = '0;
        @(posedge clk);
        #1;

        add_frame(8'h12, 1'b1, 1'b1, 0, 1, 1);
        add_frame(8'h0F, 1'b1, 1'b1, 0, 0, 0);
        add_frame(8'hF0, 1'b1, 1'b1, 0, 1, 3);
        add_idle(2, 1'b1);
        add_random(60);
        run_stream();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
